ram_burst_ctrl: RTL and testbench

- Initiator for the team's single-port, async-read RAM (sync write on clk, combinational read of the addressed word).
- Accepts burst write/read commands on a valid/ready command channel and streams data over valid/ready write-data and read-data channels.
- Drives the RAM's din/add/wr_en and consumes its dout.
- Sits between a host/DMA-style client and one RAM instance; one burst is in flight at a time.

---
 rtl/ram_burst_ctrl.sv | 142 ++++++++++++++
 tb/tb_ram_burst_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_ctrl.sv
// Burst initiator for a single-port async-read RAM: valid/ready command, write-data and read-data channels.
// Optional clear-to-zero command enabled by defining RAM_BURST_CTRL_CLEAR_EN.
module ram_burst_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
`ifdef RAM_BURST_CTRL_CLEAR_EN
  input  logic              cmd_clear,
`endif
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] ram_din,
  output logic [ADDR_W-1:0] ram_add,
  output logic              ram_wr_en,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
`ifdef RAM_BURST_CTRL_CLEAR_EN
    ,
    CLEAR = 2'd3
`endif
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] remaining;
  logic              cmd_fire;
  logic              step;
  logic              rd_load;
  logic              rd_hs;
  logic              final_beat;

  assign final_beat = (remaining == '0);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign rd_hs      = rdata_valid && rdata_ready;
  assign ram_add    = addr;
  assign busy       = (state != IDLE) || rdata_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    ram_wr_en   = 1'b0;
    ram_din     = '0;
    step        = 1'b0;
    rd_load     = 1'b0;
    case (state)
      IDLE: begin
        // a draining read beat blocks new commands so bursts never overlap
        cmd_ready = rst_n && !rdata_valid;
        if (cmd_valid && cmd_ready) begin
`ifdef RAM_BURST_CTRL_CLEAR_EN
          if (cmd_clear) state_nxt = CLEAR;
          else
`endif
          state_nxt = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        wdata_ready = 1'b1;
        ram_din     = wdata;
        ram_wr_en   = rst_n && wdata_valid;
        step        = wdata_valid;
        if (wdata_valid && final_beat) state_nxt = IDLE;
      end
      READ: begin
        rd_load = !rdata_valid || rdata_ready;
        step    = rd_load;
        if (rd_load && final_beat) state_nxt = IDLE;
      end
`ifdef RAM_BURST_CTRL_CLEAR_EN
      CLEAR: begin
        ram_wr_en = rst_n;
        step      = 1'b1;
        if (final_beat) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr        <= '0;
      remaining   <= '0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      rdata_last  <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cmd_fire) begin
        addr      <= cmd_addr;
        remaining <= cmd_len;
`ifdef RAM_BURST_CTRL_CLEAR_EN
        // full-depth sweep regardless of the requested length
        if (cmd_clear) remaining <= '1;
`endif
      end
      if (step) begin
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - ADDR_W'(1);
      end
      if (state == WRITE && wdata_valid && final_beat) done <= 1'b1;
`ifdef RAM_BURST_CTRL_CLEAR_EN
      if (state == CLEAR && final_beat) done <= 1'b1;
`endif
      if (rd_load) begin
        rdata       <= ram_dout;
        rdata_valid <= 1'b1;
        rdata_last  <= final_beat;
      end else if (rd_hs) begin
        rdata_valid <= 1'b0;
      end
      if (rd_hs && rdata_last) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Self-checking bench for ram_burst_ctrl with a behavioural RAM and a word-array reference model.
// Exercises the clear command too when RAM_BURST_CTRL_CLEAR_EN is defined.
module tb_ram_burst_ctrl;

  typedef logic [7:0] blk_t [16];
  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [3:0]  len;
    int          rmode;
    logic [31:0] d;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_write;
`ifdef RAM_BURST_CTRL_CLEAR_EN
  logic       cmd_clear;
`endif
  logic [3:0] cmd_addr, cmd_len;
  logic       wdata_valid, wdata_ready;
  logic [7:0] wdata;
  logic       rdata_valid, rdata_ready, rdata_last;
  logic [7:0] rdata;
  logic       busy, done;
  logic [7:0] ram_din, ram_dout;
  logic [3:0] ram_add;
  logic       ram_wr_en;

  logic [7:0] mem [16];
  logic [7:0] ref_mem [16];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_wr_en) mem[ram_add] <= ram_din;
  assign ram_dout = mem[ram_add];

  ram_burst_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
`ifdef RAM_BURST_CTRL_CLEAR_EN
    .cmd_clear(cmd_clear),
`endif
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last), .busy(busy), .done(done),
    .ram_din(ram_din), .ram_add(ram_add), .ram_wr_en(ram_wr_en), .ram_dout(ram_dout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue_cmd(input bit wr, input bit clr, input logic [3:0] a, input logic [3:0] l);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = l;
`ifdef RAM_BURST_CTRL_CLEAR_EN
    cmd_clear = clr;
`else
    if (clr) check("clear_unsupported", 1, 0);
`endif
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = 4'($urandom);
    cmd_len   = 4'($urandom);
`ifdef RAM_BURST_CTRL_CLEAR_EN
    cmd_clear = 1'b0;
`endif
  endtask

  task automatic write_burst(input logic [3:0] a, input logic [3:0] l, input blk_t d, input bit stall);
    int beat = 0;
    int cyc = 0;
    logic [3:0] p = a;
    bit v;
    issue_cmd(1'b1, 1'b0, a, l);
    while (beat <= int'(l) && cyc < 200) begin
      @(negedge clk);
      v = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      wdata_valid = v;
      wdata = v ? d[beat] : 8'($urandom);
      #1;
      check("wdata_ready", wdata_ready, 1);
      check("wr_en", ram_wr_en, v);
      if (v) begin
        check("wr_add", ram_add, p);
        check("wr_din", ram_din, d[beat]);
        ref_mem[p] = d[beat];
        p++;
        beat++;
      end
      cyc++;
    end
    check("wr_beats", beat, l + 1);
    @(negedge clk);
    wdata_valid = 1'b0;
    #1;
    check("wr_done", done, 1);
    check("wr_idle_ready", wdata_ready, 0);
    @(negedge clk);
    #1;
    check("wr_done_once", done, 0);
    for (int i = 0; i <= int'(l); i++) check("ram_word", mem[4'(a + i)], d[i]);
  endtask

  task automatic read_burst(input logic [3:0] a, input logic [3:0] l, input blk_t e, input int mode);
    int got = 0;
    int cyc = 0;
    bit r;
    bit pv = 1'b0;
    bit pr = 1'b0;
    logic [7:0] pd = '0;
    logic pl = 1'b0;
    issue_cmd(1'b0, 1'b0, a, l);
    while (got <= int'(l) && cyc < 300) begin
      @(negedge clk);
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      rdata_ready = r;
      #1;
      if (cyc == 0) check("rd_latency0", rdata_valid, 0);
      if (cyc == 1) check("rd_latency1", rdata_valid, 1);
      check("rd_wr_en", ram_wr_en, 0);
      if (pv && !pr) begin
        check("rd_hold_valid", rdata_valid, 1);
        check("rd_hold_data", rdata, pd);
        check("rd_hold_last", rdata_last, pl);
      end
      if (rdata_valid && r) begin
        check("rd_data", rdata, e[got]);
        check("rd_last", rdata_last, got == int'(l));
        got++;
      end
      pv = rdata_valid;
      pr = r;
      pd = rdata;
      pl = rdata_last;
      cyc++;
    end
    check("rd_beats", got, l + 1);
    if (mode == 0) check("rd_throughput", cyc, l + 2);
    @(negedge clk);
    rdata_ready = 1'b0;
    #1;
    check("rd_done", done, 1);
    check("rd_drained", rdata_valid, 0);
    @(negedge clk);
    #1;
    check("rd_done_once", done, 0);
  endtask

  function automatic blk_t ref_blk(input logic [3:0] a);
    blk_t b;
    for (int i = 0; i < 16; i++) b[i] = ref_mem[4'(a + i)];
    return b;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [4];
    blk_t blk;
    logic [3:0] ra, rl;

    tbl[0] = '{1'b1, 4'd3,  4'd1, 0, 32'h0000_55AA};
    tbl[1] = '{1'b0, 4'd3,  4'd1, 0, 32'h0000_55AA};
    tbl[2] = '{1'b1, 4'd14, 4'd3, 0, 32'h0403_0201};
    tbl[3] = '{1'b0, 4'd14, 4'd3, 1, 32'h0403_0201};

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
`ifdef RAM_BURST_CTRL_CLEAR_EN
    cmd_clear = 1'b0;
`endif
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
    #1;
    check("wr_en_pre_reset", ram_wr_en, 0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rdata_valid", rdata_valid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rdata_last", rdata_last, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_add", ram_add, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("idle_cmd_ready", cmd_ready, 1);
    wdata_valid = 1'b1;
    wdata = 8'h77;
    #1;
    check("idle_wdata_ready", wdata_ready, 0);
    check("idle_wr_en", ram_wr_en, 0);
    @(negedge clk);
    wdata_valid = 1'b0;

    for (int i = 0; i < 16; i++) blk[i] = 8'($urandom);
    write_burst(4'd0, 4'd15, blk, 1'b0);

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) blk[i] = (i < 4) ? tbl[k].d[8*i +: 8] : 8'h00;
      if (tbl[k].wr) write_burst(tbl[k].addr, tbl[k].len, blk, 1'b0);
      else           read_burst(tbl[k].addr, tbl[k].len, blk, tbl[k].rmode);
    end

    issue_cmd(1'b0, 1'b0, 4'd0, 4'd0);
    rdata_ready = 1'b0;
    @(negedge clk);
    #1;
    check("stall_first", rdata_valid, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("stall_valid", rdata_valid, 1);
      check("stall_data", rdata, 8'h03);
      check("stall_last", rdata_last, 1);
      check("stall_cmd_ready", cmd_ready, 0);
      check("stall_busy", busy, 1);
      check("stall_done", done, 0);
    end
    rdata_ready = 1'b1;
    @(negedge clk);
    rdata_ready = 1'b0;
    #1;
    check("stall_hs_done", done, 1);
    check("stall_hs_valid", rdata_valid, 0);
    check("stall_hs_busy", busy, 0);
    check("stall_hs_ready", cmd_ready, 1);

    issue_cmd(1'b1, 1'b0, 4'd8, 4'd3);
    @(negedge clk); wdata_valid = 1'b1; wdata = 8'h11;
    @(negedge clk); wdata = 8'h22;
    @(negedge clk); wdata = 8'h33; rst_n = 1'b0;
    #1;
    check("midrst_wr_en", ram_wr_en, 0);
    @(negedge clk);
    wdata_valid = 1'b0;
    #1;
    check("midrst_done", done, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    check("midrst_wdata_ready", wdata_ready, 0);
    check("midrst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_idle", cmd_ready, 1);
    check("midrst_done2", done, 0);
    check("midrst_w0", mem[8], 8'h11);
    check("midrst_w1", mem[9], 8'h22);
    check("midrst_keep2", mem[10], ref_mem[10]);
    check("midrst_keep3", mem[11], ref_mem[11]);
    ref_mem[8] = 8'h11;
    ref_mem[9] = 8'h22;
    read_burst(4'd8, 4'd3, ref_blk(4'd8), 0);

    for (int k = 0; k < 14; k++) begin
      ra = 4'($urandom);
      rl = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) blk[i] = 8'($urandom);
        write_burst(ra, rl, blk, 1'b1);
      end else begin
        read_burst(ra, rl, ref_blk(ra), 2);
      end
    end
    read_burst(4'd9, 4'd15, ref_blk(4'd9), 0);

`ifdef RAM_BURST_CTRL_CLEAR_EN
    for (int i = 0; i < 16; i++) blk[i] = 8'hFF;
    write_burst(4'd0, 4'd15, blk, 1'b0);
    issue_cmd(1'b0, 1'b1, 4'd5, 4'd2);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1;
      check("clr_wr_en", ram_wr_en, 1);
      check("clr_add", ram_add, 4'(5 + i));
      check("clr_din", ram_din, 0);
      check("clr_wdata_ready", wdata_ready, 0);
      check("clr_done_early", done, 0);
    end
    @(negedge clk);
    #1;
    check("clr_done", done, 1);
    check("clr_wr_en_off", ram_wr_en, 0);
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    read_burst(4'd0, 4'd15, ref_blk(4'd0), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
